// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: datapath width, the Booth multiplier
// state encoding and the radix-4 Booth digit encoding.
package cpu_defs_pkg;

  // Native datapath width of the CPU (register Y, bus, HI, LO).
  localparam int CPU_WIDTH = 32;

  // Sequencer states of the Booth multiplier.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } booth_state_e;

  // One radix-4 Booth digit in sign/magnitude form:
  // the value is (neg ? -1 : +1) * (two ? 2 : (one ? 1 : 0)).
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a digit in {-2, -1, 0, +1, +2}, given as sign plus one-hot magnitude.
module booth_r4_encoder (
  input  logic [2:0] bits,
  output logic       neg,
  output logic       one,
  output logic       two
);

  // Digit value is -2*bits[2] + bits[1] + bits[0]; 3'b111 is zero, so it is
  // reported as positive to avoid a pointless negate of zero.
  always_comb begin
    one = bits[1] ^ bits[0];
    two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    neg = bits[2] & ~(bits[1] & bits[0]);
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier producing the 2*WIDTH-bit product
// for Z (result_hi -> Zhigh/HI, result_lo -> Zlow/LO).
// Optional build macro: BOOTH_UNSIGNED_EN adds the mul_unsigned input and an
// extra iteration for zero-extended (unsigned) operands.
//
// Handshake: start is sampled on each rising edge and is accepted only in
// IDLE or FIN (never while busy). busy is high for exactly the iterating
// cycles; done is a one-cycle pulse in the cycle after the last iteration,
// and result_hi/result_lo are valid from that cycle until the next final
// iteration. busy and done are decoded from distinct states, so they are
// never high together. Operands are sampled only on the accept edge.
module booth_mul_seq
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             mul_unsigned,
`endif
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int HALF = WIDTH / 2;
  // Upper (partial product) field: two guard bits so +/-2A never overflows.
  localparam int UW   = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
  // Multiplier field carries two extension bits so unsigned operands get one
  // more digit window covering the zero-extended MSB.
  localparam int BW   = WIDTH + 2;
`else
  localparam int BW   = WIDTH;
`endif
  localparam int AW   = UW + BW + 1;
  localparam int CW   = $clog2(HALF + 2);

  booth_state_e     r_state;
  booth_state_e     w_state_nxt;
  logic [UW-1:0]    r_a;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    w_last_cnt;
  logic [UW-1:0]    w_a_ext;
  logic [BW-1:0]    w_b_ext;
  booth_digit_t     w_digit;
  logic [UW-1:0]    w_upper;
  logic [UW-1:0]    w_mag;
  logic [UW-1:0]    w_upper_sum;
  logic [AW-1:0]    w_acc_sum;
  logic [AW-1:0]    w_acc_nxt;
  logic [2*WIDTH-1:0] w_product;

  // Operand extension and per-operation step count.
`ifdef BOOTH_UNSIGNED_EN
  logic r_uns;
  logic w_sx_a;
  logic w_sx_b;

  assign w_sx_a     = ~mul_unsigned & multiplicand[WIDTH-1];
  assign w_sx_b     = ~mul_unsigned & multiplier[WIDTH-1];
  assign w_a_ext    = {{2{w_sx_a}}, multiplicand};
  assign w_b_ext    = {{2{w_sx_b}}, multiplier};
  assign w_last_cnt = r_uns ? CW'(HALF) : CW'(HALF - 1);
`else
  assign w_a_ext    = {{2{multiplicand[WIDTH-1]}}, multiplicand};
  assign w_b_ext    = multiplier;
  assign w_last_cnt = CW'(HALF - 1);
`endif

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
  assign w_last   = (r_cnt == w_last_cnt);

  booth_r4_encoder u_enc (
    .bits (r_acc[2:0]),
    .neg  (w_digit.neg),
    .one  (w_digit.one),
    .two  (w_digit.two)
  );

  // One Booth step: add d*A into the upper field, then arithmetic shift by 2.
  assign w_upper     = r_acc[AW-1 -: UW];
  assign w_mag       = w_digit.two ? {r_a[UW-2:0], 1'b0} :
                       (w_digit.one ? r_a : '0);
  assign w_upper_sum = w_digit.neg ? (w_upper - w_mag) : (w_upper + w_mag);
  assign w_acc_sum   = {w_upper_sum, r_acc[BW:0]};
  assign w_acc_nxt   = $signed(w_acc_sum) >>> 2;

  // Product position depends on how far the accumulator has been shifted:
  // WIDTH/2 steps leave it at bit (BW-WIDTH)+1, WIDTH/2+1 steps at bit 1.
`ifdef BOOTH_UNSIGNED_EN
  assign w_product = r_uns ? w_acc_nxt[2*WIDTH:1] : w_acc_nxt[2*WIDTH+2:3];
`else
  assign w_product = w_acc_nxt[2*WIDTH:1];
`endif

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start during CALC is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = start ? ST_CALC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, latch the product
  // on the final iteration. Results persist across later accepts.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_a      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
`ifdef BOOTH_UNSIGNED_EN
      r_uns    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= w_a_ext;
      r_acc <= {{UW{1'b0}}, w_b_ext, 1'b0};
      r_cnt <= '0;
`ifdef BOOTH_UNSIGNED_EN
      r_uns <= mul_unsigned;
`endif
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_res_hi <= w_product[2*WIDTH-1:WIDTH];
        r_res_lo <= w_product[WIDTH-1:0];
      end
    end
  end

  assign busy      = (r_state == ST_CALC);
  assign done      = (r_state == ST_FIN);
  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases plus random
// operands, compared against a plain-arithmetic product model.
// Optional build macro: BOOTH_UNSIGNED_EN enables the unsigned-mode steps.
module tb_booth_mul_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
`ifdef BOOTH_UNSIGNED_EN
  logic         mul_unsigned;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
`ifdef BOOTH_UNSIGNED_EN
    .mul_unsigned (mul_unsigned),
`endif
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  // Clock
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit uns);
    longint sa, sb;
    logic [2*W-1:0] ua, ub;
    if (uns) begin
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      return ua * ub;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Wait (bounded) for done; lat counts edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_exp(output logic [2*W-1:0] v);
    if (exp_q.size() > 0) v = exp_q.pop_front();
    else v = 'x;
  endtask

  // One complete multiply with a single-cycle start pulse.
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit uns);
    int lat;
    int exp_lat;
    logic [2*W-1:0] exp_p;
    multiplicand = a;
    multiplier   = b;
`ifdef BOOTH_UNSIGNED_EN
    mul_unsigned = uns;
    exp_lat = uns ? W/2 + 1 : W/2;
`else
    exp_lat = W/2;
`endif
    exp_q.push_back(model(a, b, uns));
    start = 1'b1;
    tick();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
`ifdef BOOTH_UNSIGNED_EN
    mul_unsigned = $urandom_range(0, 1);
`endif
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_with_done"}, 64'(busy), 64'd0);
    pop_exp(exp_p);
    check({tag, " product"}, {result_hi, result_lo}, exp_p);
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " result_hold"}, {result_hi, result_lo}, exp_p);
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] p_first;
    int lat;

    clear        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
`ifdef BOOTH_UNSIGNED_EN
    mul_unsigned = 1'b0;
`endif
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", {result_hi, result_lo}, 64'd0);
    clear = 1'b1;
    tick();
    check("idle done", 64'(done), 64'd0);

    // Directed corners
    do_mul("21x-3", 32'd21, 32'hFFFF_FFFD, 1'b0);
    do_mul("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_mul("maxx-1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mul("zeroA", 32'd0, $urandom, 1'b0);
    do_mul("zeroB", $urandom, 32'd0, 1'b0);
    do_mul("minxmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    do_mul("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      do_mul("random", $urandom, $urandom, 1'b0);
    end

    // start held through CALC with changing operands; re-accept on done edge
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    multiplicand = a1;
    multiplier   = b1;
`ifdef BOOTH_UNSIGNED_EN
    mul_unsigned = 1'b0;
`endif
    start = 1'b1;
    tick();
    multiplicand = a2;
    multiplier   = b2;
    wait_done(lat);
    check("hold first_latency", 64'(lat), 64'd16);
    p_first = model(a1, b1, 1'b0);
    check("hold first_product", {result_hi, result_lo}, p_first);
    tick();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    check("hold reaccept_busy", 64'(busy), 64'd1);
    check("hold result_kept", {result_hi, result_lo}, p_first);
    wait_done(lat);
    check("hold second_gap", 64'(lat + 1), 64'd17);
    check("hold second_product", {result_hi, result_lo}, model(a2, b2, 1'b0));

    // Asynchronous clear in the middle of CALC
    tick();
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0000_0ABC;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("midcalc busy", 64'(busy), 64'd1);
    #2;
    clear = 1'b0;
    #1;
    check("clear busy", 64'(busy), 64'd0);
    check("clear done", 64'(done), 64'd0);
    check("clear result", {result_hi, result_lo}, 64'd0);
    tick();
    tick();
    check("clear held_done", 64'(done), 64'd0);
    clear = 1'b1;
    tick();
    check("after_clear idle_done", 64'(done), 64'd0);
    check("after_clear idle_busy", 64'(busy), 64'd0);
    do_mul("5x6", 32'd5, 32'd6, 1'b0);

`ifdef BOOTH_UNSIGNED_EN
    do_mul("uns ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_mul("sgn ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_mul("uns random", $urandom, $urandom, 1'b1);
      do_mul("mix random", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequential radix-4 Booth multiplier for the CPU datapath ALU. It produces the 64-bit product that the datapath loads into Z, with Zhigh feeding HI and Zlow feeding LO. The multiplicand is taken from register Y and the multiplier from the bus. The control unit pulses `start` in the Zin step of MUL and waits for `done` before issuing Zlowout/LOin and Zhighout/HIin.

## Interface
- `WIDTH`, default 32: operand width. Must be even. The product is 2*WIDTH wide.
- `clock`, in, 1: rising-edge clock.
- `clear`, in, 1: asynchronous reset, active-low (0 = reset).
- `start`, in, 1: request a multiply. Sampled on the rising edge.
- `multiplicand`, in, WIDTH: operand A, from register Y.
- `multiplier`, in, WIDTH: operand B, from the bus.
- `busy`, out, 1: high while an operation is iterating.
- `done`, out, 1: one-cycle pulse; the result is valid from this cycle onward.
- `result_hi`, out, WIDTH: upper half of the product, to Zhigh.
- `result_lo`, out, WIDTH: lower half of the product, to Zlow.

## Operation
- **States:**
  - IDLE: go to CALC on `start`.
  - CALC: go to FIN when the step counter reaches its last value.
  - FIN: go to CALC on `start`; otherwise go to IDLE.
- **Accepting an operation:** `start` is accepted in IDLE or FIN only.
  - `start` while in CALC is ignored; the captured operands are not disturbed.
- **Capture edge (accept edge):**
  - A is sign-extended to WIDTH+2 bits.
  - The accumulator is loaded as {(WIDTH+2)'b0, B, 1'b0}.
  - The step counter is cleared.
- **Each CALC edge:**
  - Decode bits [2:0] of the accumulator into a digit d in {-2, -1, 0, +1, +2}.
  - Add d*A into the upper WIDTH+2 bits.
  - Shift the whole accumulator arithmetically right by 2.
  - Increment the counter.
- **Step count:** WIDTH/2 CALC steps (16 for WIDTH=32).
- **Arithmetic:** two's complement throughout. The upper field is WIDTH+2 bits, so ±2A cannot overflow.
- **Result:** the product is accumulator bits [2*WIDTH:1].
  - `result_hi`/`result_lo` are registered on the final CALC edge.
  - They hold their value until the next final CALC edge. A new `start` does not clear them.
- **Reset** (`clear`=0, at any time, including mid-CALC):
  - State goes to IDLE; the counter and accumulator are zeroed.
  - `busy`=0, `done`=0, `result_hi`=0, `result_lo`=0.
  - The operation in flight is discarded, with no `done`.
- **Degenerate operands** need no special handling: A=0 or B=0 gives 0; -2^(WIDTH-1) squared gives 2^(2*WIDTH-2).

## Timing
- Accept edge N: `busy`=1 after edge N.
- CALC edges: N+1 through N+WIDTH/2.
- After edge N+WIDTH/2: `busy`=0, `done`=1, results valid.
  - For WIDTH=32, latency is 16 cycles from the accept edge to `done` high.
- After edge N+WIDTH/2+1: `done`=0.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted on that edge. The next `done` follows WIDTH/2+1 edges later, with no idle bubble.
- `busy` and `done` are never high together.
- Operands are sampled only on the accept edge; they may change freely afterward.

## Configuration
- **`BOOTH_UNSIGNED_EN`**
  - **Defined:**
    - Adds input `mul_unsigned` (1 bit, sampled on the accept edge).
    - When it is 1, A and B are zero-extended to WIDTH+2 bits.
    - WIDTH/2+1 CALC steps run, giving latency 17 for WIDTH=32.
    - When it is 0, behaviour and latency are identical to the undefined build.
  - **Undefined:** the port is absent; signed only; WIDTH/2 steps.

## Structure
- **Shared package `cpu_defs_pkg`:**
  - Booth state enum (IDLE, CALC, FIN).
  - `CPU_WIDTH` = 32.
  - Booth digit encoding type.
- **Sub-module `booth_r4_encoder`:** combinational.
  - Input: 3 multiplier bits.
  - Outputs: `neg`, `one`, `two`.
  - Instantiated once.
- Everything else (FSM, counter, accumulator, result registers) lives in `booth_mul_seq`.

## Test plan
- A=21, B=-3, `start` for one cycle -> `done` 16 cycles after accept; `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFC1 (-63).
- A=0x80000000, B=0x80000000 -> `result_hi`=0x40000000, `result_lo`=0x00000000. Also A=0x7FFFFFFF, B=-1 -> hi=0xFFFFFFFF, lo=0x80000001.
- `start` held high throughout CALC with different operands -> exactly one `done` for the original operands. A second operation is accepted on the `done` edge, and its result arrives 17 edges after the first `done`.
- `clear`=0 at CALC step 7 -> all outputs 0 asynchronously, state IDLE. After release, a new 5×6 multiply gives hi=0, lo=30 with normal latency.
- `BOOTH_UNSIGNED_EN` defined:
  - 0xFFFFFFFF×0xFFFFFFFF, `mul_unsigned`=1 -> hi=0xFFFFFFFE, lo=0x00000001 after 17 cycles.
  - Same operands with `mul_unsigned`=0 -> hi=0, lo=1 after 16 cycles.
